instr_mem_loadable: RTL and testbench
=====================================

Name: instr_mem_loadable

Overview:
- Next-generation instruction memory for the CPU fetch stage.
- Parametrised depth and instruction width. The program is written through a load port after reset, so no hard-coded contents.
- Synchronous, registered read behind a req/ready/valid fetch handshake.
- Out-of-range and unwritten addresses return a HALT instruction.
- Two-state load/run controller write-protects the program once running.

Parameters:
- ROM_SIZE, 256: number of instruction words; power of two, at least 2.
- INSTR_WIDTH, 9: bits per instruction.
- HALT_INSTR, 9'b111000000: word returned for unwritten or out-of-range addresses; width INSTR_WIDTH.
- AW (derived, not overridable), $clog2(ROM_SIZE): in-range address width.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- load_en, in, 1: write strobe for the load port.
- load_addr, in, AW: write address.
- load_data, in, INSTR_WIDTH: word to write.
- load_done, in, 1: single-cycle pulse ending the load phase.
- load_active, out, 1: high while in LOAD.
- load_err, out, 1: sticky; set when a write is attempted in RUN.
- words_loaded, out, AW+1: count of distinct addresses written since reset.
- fetch_req, in, 1: fetch request.
- fetch_addr, in, AW+1: fetch address; the extra MSB allows out-of-range detection.
- fetch_ready, out, 1: high in RUN only.
- instr_valid, out, 1: high for one cycle per accepted fetch.
- instr_out, out, INSTR_WIDTH: fetched instruction, registered.
- addr_err, out, 1: qualified by instr_valid; high when the fetch address was >= ROM_SIZE.

Behaviour:
- Reset (asynchronous, while reset=1):
  - state goes to LOAD.
  - instr_valid=0, instr_out=0, addr_err=0, load_err=0, words_loaded=0.
  - All per-entry written bits cleared.
  - Memory array contents are not reset. They are masked by the written bits.
- Storage:
  - Array of ROM_SIZE x INSTR_WIDTH words.
  - Array of ROM_SIZE written bits, one per entry.
- State LOAD:
  - load_active=1, fetch_ready=0. fetch_req is ignored and produces no instr_valid.
  - On load_en=1: mem[load_addr] <= load_data and written[load_addr] <= 1.
  - words_loaded increments only if written[load_addr] was 0. Rewriting an address overwrites the data without incrementing.
  - On load_done=1: go to RUN next cycle.
  - load_en and load_done in the same cycle: the write is performed, then the transition happens.
  - Loading zero words is legal; every fetch then returns HALT_INSTR.
- State RUN:
  - load_active=0, fetch_ready=1.
  - load_en=1 performs no write and sets load_err (sticky until reset).
  - load_done is ignored.
  - RUN is left only by reset.
- Fetch:
  - Accepted when fetch_req && fetch_ready.
  - Latency is one cycle: on the next edge instr_valid=1 and instr_out is set as follows.
    - fetch_addr >= ROM_SIZE: HALT_INSTR with addr_err=1.
    - Entry not written: HALT_INSTR with addr_err=0.
    - Otherwise: mem[fetch_addr] with addr_err=0.
  - Back-to-back fetches are accepted every cycle: full throughput, no bubbles.
  - In a cycle with no accepted fetch: instr_valid=0, addr_err=0, and instr_out holds its last value.
- Reset mid-operation: an in-flight fetch is dropped, with no instr_valid after reset deasserts. The program must be reloaded.

Test Plan:
- Load and fetch: reset; load 0→9'b001000110, 1→9'b001010100, 17→9'b111000000; pulse load_done; fetch addr 1 → next cycle instr_valid=1, instr_out=9'b001010100, addr_err=0; words_loaded=3.
- Unwritten and out-of-range: after the load above, fetch addr 5 → HALT_INSTR, addr_err=0; fetch addr 256 (ROM_SIZE=256) → HALT_INSTR, addr_err=1.
- Handshake gating: in LOAD, assert fetch_req at addr 0 for 3 cycles → fetch_ready=0, instr_valid stays 0. In RUN, fetch addrs 0,1,0 on consecutive cycles → three consecutive valids 9'b001000110, 9'b001010100, 9'b001000110.
- Write protection: in RUN, load_en=1 at addr 0 with data 9'h1FF → load_err=1 and stays 1; a later fetch of addr 0 returns 9'b001000110.
- Same-cycle events: load_en at addr 3 with data 9'h0AA together with load_done → fetch addr 3 returns 9'h0AA. Rewriting addr 0 twice in LOAD → words_loaded increments once.
- Reset mid-operation: assert reset asynchronously between clock edges during a fetch stream → instr_valid drops to 0 immediately and state is LOAD. After release, fetch of addr 0 following load_done with no reload returns HALT_INSTR; words_loaded=0.

Source files
------------

// File: rtl/instr_mem_loadable_if.sv
// Load-port and fetch-handshake bundle between the CPU fetch stage (master)
// and the loadable instruction memory (slave).
interface instr_mem_loadable_if #(
    parameter int ROM_SIZE    = 256,
    parameter int INSTR_WIDTH = 9
);
    localparam int AW = $clog2(ROM_SIZE);

    logic                   load_en;
    logic [AW-1:0]          load_addr;
    logic [INSTR_WIDTH-1:0] load_data;
    logic                   load_done;
    logic                   load_active;
    logic                   load_err;
    logic [AW:0]            words_loaded;
    logic                   fetch_req;
    logic [AW:0]            fetch_addr;
    logic                   fetch_ready;
    logic                   instr_valid;
    logic [INSTR_WIDTH-1:0] instr_out;
    logic                   addr_err;

    modport master (
        output load_en, load_addr, load_data, load_done, fetch_req, fetch_addr,
        input  load_active, load_err, words_loaded, fetch_ready,
               instr_valid, instr_out, addr_err
    );

    modport slave (
        input  load_en, load_addr, load_data, load_done, fetch_req, fetch_addr,
        output load_active, load_err, words_loaded, fetch_ready,
               instr_valid, instr_out, addr_err
    );
endinterface

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: program written in LOAD, then write-protected
// and read through a one-cycle registered fetch handshake in RUN.
module instr_mem_loadable #(
    parameter int                     ROM_SIZE    = 256,
    parameter int                     INSTR_WIDTH = 9,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = 9'b111000000
) (
    input logic                 clk,
    input logic                 reset,
    instr_mem_loadable_if.slave bus
);
    localparam int          AW       = $clog2(ROM_SIZE);
    localparam logic [AW:0] WORD_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

    state_t                 state;
    logic [INSTR_WIDTH-1:0] mem [ROM_SIZE];
    logic [ROM_SIZE-1:0]    written;
    logic                   load_active;
    logic                   fetch_ready;
    logic                   load_err;
    logic [AW:0]            words_loaded;

    logic                   wr_p0;
    logic                   fetch_p0;
    logic                   in_range_p0;
    logic [AW-1:0]          rd_idx_p0;

    logic                   vld_p1;
    logic [INSTR_WIDTH-1:0] instr_p1;
    logic                   addr_err_p1;

    // Unwritten or out-of-range entries read as HALT so stale RAM never leaks out.
    function automatic logic [INSTR_WIDTH-1:0] select_instr(
        input logic                   in_range,
        input logic                   was_written,
        input logic [INSTR_WIDTH-1:0] word
    );
        return (in_range && was_written) ? word : HALT_INSTR;
    endfunction

    // Stage p0: request decode
    assign wr_p0       = bus.load_en && (state == LOAD);
    assign fetch_p0    = bus.fetch_req && (state == RUN);
    assign in_range_p0 = ~bus.fetch_addr[AW];
    assign rd_idx_p0   = bus.fetch_addr[AW-1:0];

    always_ff @(posedge clk) begin
        if (wr_p0) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= LOAD;
            load_active  <= 1'b1;
            fetch_ready  <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            written      <= '0;
            vld_p1       <= 1'b0;
            addr_err_p1  <= 1'b0;
            instr_p1     <= '0;
        end else begin
            if (state == LOAD) begin
                if (wr_p0) begin
                    written[bus.load_addr] <= 1'b1;
                    if (!written[bus.load_addr]) begin
                        words_loaded <= words_loaded + WORD_ONE;
                    end
                end
                if (bus.load_done) begin
                    state       <= RUN;
                    load_active <= 1'b0;
                    fetch_ready <= 1'b1;
                end
            end else if (bus.load_en) begin
                load_err <= 1'b1;
            end

            // Stage p1: registered fetch result
            vld_p1      <= fetch_p0;
            addr_err_p1 <= fetch_p0 && !in_range_p0;
            if (fetch_p0) begin
                instr_p1 <= select_instr(in_range_p0, written[rd_idx_p0], mem[rd_idx_p0]);
            end
        end
    end

    assign bus.load_active  = load_active;
    assign bus.fetch_ready  = fetch_ready;
    assign bus.load_err     = load_err;
    assign bus.words_loaded = words_loaded;
    assign bus.instr_valid  = vld_p1;
    assign bus.instr_out    = instr_p1;
    assign bus.addr_err     = addr_err_p1;
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: array-based program model checked every cycle,
// plus directed load/fetch/protection/reset scenarios with literal expectations.
module tb_instr_mem_loadable;
    localparam int         ROM_SIZE = 256;
    localparam logic [8:0] HALT     = 9'b111000000;
    localparam logic [8:0] W0       = 9'b001000110;
    localparam logic [8:0] W1       = 9'b001010100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_mem_loadable_if #(.ROM_SIZE(ROM_SIZE), .INSTR_WIDTH(9)) bus();

    instr_mem_loadable #(.ROM_SIZE(ROM_SIZE), .INSTR_WIDTH(9), .HALT_INSTR(HALT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Program model: what was loaded, whether we are running, what the last fetch returned.
    logic [8:0] m_mem [ROM_SIZE];
    bit         m_wr  [ROM_SIZE];
    bit         m_run, m_lerr, m_vld, m_aerr;
    logic [8:0] m_instr;

    function automatic int count_words();
        int n = 0;
        foreach (m_wr[i]) n += int'(m_wr[i]);
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROM_SIZE; i++) m_wr[i] <= 1'b0;
            m_run   <= 1'b0;
            m_lerr  <= 1'b0;
            m_vld   <= 1'b0;
            m_aerr  <= 1'b0;
            m_instr <= '0;
        end else begin
            if (m_run && bus.fetch_req) begin
                m_vld <= 1'b1;
                if (int'(bus.fetch_addr) >= ROM_SIZE) begin
                    m_instr <= HALT;
                    m_aerr  <= 1'b1;
                end else begin
                    m_aerr  <= 1'b0;
                    m_instr <= m_wr[int'(bus.fetch_addr)] ? m_mem[int'(bus.fetch_addr)] : HALT;
                end
            end else begin
                m_vld  <= 1'b0;
                m_aerr <= 1'b0;
            end
            if (!m_run) begin
                if (bus.load_en) begin
                    m_mem[int'(bus.load_addr)] <= bus.load_data;
                    m_wr[int'(bus.load_addr)]  <= 1'b1;
                end
                if (bus.load_done) m_run <= 1'b1;
            end else if (bus.load_en) begin
                m_lerr <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_load_active", 32'(bus.load_active), 32'(!m_run));
        chk("model_fetch_ready", 32'(bus.fetch_ready), 32'(m_run));
        chk("model_load_err", 32'(bus.load_err), 32'(m_lerr));
        chk("model_words_loaded", 32'(bus.words_loaded), 32'(count_words()));
        chk("model_instr_valid", 32'(bus.instr_valid), 32'(m_vld));
        chk("model_addr_err", 32'(bus.addr_err), 32'(m_aerr));
        chk("model_instr_out", 32'(bus.instr_out), 32'(m_instr));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic write_word(input int addr, input logic [8:0] data);
        bus.load_en   = 1'b1;
        bus.load_addr = 8'(addr);
        bus.load_data = data;
        tick();
        bus.load_en   = 1'b0;
    endtask

    task automatic fetch(input int addr, input logic [8:0] exp_instr, input logic exp_aerr);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 9'(addr);
        tick();
        chk($sformatf("fetch%0d_valid", addr), 32'(bus.instr_valid), 32'd1);
        chk($sformatf("fetch%0d_instr", addr), 32'(bus.instr_out), 32'(exp_instr));
        chk($sformatf("fetch%0d_aerr", addr), 32'(bus.addr_err), 32'(exp_aerr));
    endtask

    initial begin
        reset          = 1'b1;
        bus.load_en    = 1'b0;
        bus.load_addr  = '0;
        bus.load_data  = '0;
        bus.load_done  = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        tick();
        tick();
        chk("rst_load_active", 32'(bus.load_active), 32'd1);
        chk("rst_fetch_ready", 32'(bus.fetch_ready), 32'd0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr_out", 32'(bus.instr_out), 32'd0);
        chk("rst_load_err", 32'(bus.load_err), 32'd0);
        chk("rst_words", 32'(bus.words_loaded), 32'd0);
        reset = 1'b0;
        tick();

        // Rewrites of address 0 count once.
        write_word(0, 9'h055);
        chk("words_after_first", 32'(bus.words_loaded), 32'd1);
        write_word(0, 9'h0AB);
        write_word(0, W0);
        chk("words_after_rewrite", 32'(bus.words_loaded), 32'd1);
        write_word(1, W1);
        write_word(17, 9'b111000000);
        chk("words_three", 32'(bus.words_loaded), 32'd3);

        // Fetches during LOAD are ignored.
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("load_fetch_ready", 32'(bus.fetch_ready), 32'd0);
            chk("load_fetch_valid", 32'(bus.instr_valid), 32'd0);
        end
        bus.fetch_req = 1'b0;

        // Final write coincides with load_done.
        bus.load_en   = 1'b1;
        bus.load_addr = 8'd3;
        bus.load_data = 9'h0AA;
        bus.load_done = 1'b1;
        tick();
        bus.load_en   = 1'b0;
        bus.load_done = 1'b0;
        chk("run_load_active", 32'(bus.load_active), 32'd0);
        chk("run_fetch_ready", 32'(bus.fetch_ready), 32'd1);
        chk("run_words", 32'(bus.words_loaded), 32'd4);

        fetch(1, W1, 1'b0);
        fetch(5, HALT, 1'b0);
        fetch(256, HALT, 1'b1);
        fetch(3, 9'h0AA, 1'b0);
        fetch(17, HALT, 1'b0);
        fetch(511, HALT, 1'b1);
        fetch(0, W0, 1'b0);
        fetch(1, W1, 1'b0);
        fetch(0, W0, 1'b0);
        bus.fetch_req = 1'b0;
        tick();
        chk("idle_valid", 32'(bus.instr_valid), 32'd0);
        chk("idle_aerr", 32'(bus.addr_err), 32'd0);
        chk("idle_hold", 32'(bus.instr_out), 32'(W0));

        // Writes in RUN are blocked and flagged.
        bus.load_en   = 1'b1;
        bus.load_addr = 8'd0;
        bus.load_data = 9'h1FF;
        tick();
        bus.load_en = 1'b0;
        chk("load_err_set", 32'(bus.load_err), 32'd1);
        bus.load_done = 1'b1;
        tick();
        bus.load_done = 1'b0;
        tick();
        chk("load_err_sticky", 32'(bus.load_err), 32'd1);
        chk("run_stays_run", 32'(bus.fetch_ready), 32'd1);
        fetch(0, W0, 1'b0);

        // Asynchronous reset during a fetch stream.
        bus.fetch_addr = 9'd1;
        tick();
        #1;
        reset = 1'b1;
        #1;
        chk("async_valid", 32'(bus.instr_valid), 32'd0);
        chk("async_load_active", 32'(bus.load_active), 32'd1);
        chk("async_fetch_ready", 32'(bus.fetch_ready), 32'd0);
        chk("async_words", 32'(bus.words_loaded), 32'd0);
        tick();
        reset          = 1'b0;
        bus.fetch_addr = '0;
        tick();
        chk("post_rst_valid", 32'(bus.instr_valid), 32'd0);
        bus.fetch_req = 1'b0;
        bus.load_done = 1'b1;
        tick();
        bus.load_done = 1'b0;
        chk("empty_run_ready", 32'(bus.fetch_ready), 32'd1);
        chk("empty_words", 32'(bus.words_loaded), 32'd0);
        fetch(0, HALT, 1'b0);
        bus.fetch_req = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
